// File: rtl/dram_axi_arbiter.sv
// dram_axi_arbiter: two AXI4 masters (m0 = core, m1 = Ethernet DMA) sharing one DRAM slave port.
// Read and write paths are arbitrated independently, round-robin, one burst in flight per path.
// Responses are routed by the locked grant, not by ID.
// Ports:
//   clock, reset                  system clock, asynchronous active-high reset
//   io_mN_aw_* / io_mN_w_* / io_mN_b_*   master N write address / data / response
//   io_mN_ar_* / io_mN_r_*               master N read address / data
//   io_s_*                        same channel set toward the DRAM slave, directions reversed
// AX payload layout: {id, addr, len, size[2:0], burst[1:0]}.
module dram_axi_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned LEN_WIDTH  = 8,
    localparam int unsigned XW        = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5,
    localparam int unsigned SW        = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    // master 0
    input  logic                  io_m0_aw_valid,
    output logic                  io_m0_aw_ready,
    input  logic [XW-1:0]         io_m0_aw_bits,
    input  logic                  io_m0_w_valid,
    output logic                  io_m0_w_ready,
    input  logic [DATA_WIDTH-1:0] io_m0_w_data,
    input  logic [SW-1:0]         io_m0_w_strb,
    input  logic                  io_m0_w_last,
    output logic                  io_m0_b_valid,
    input  logic                  io_m0_b_ready,
    output logic [ID_WIDTH-1:0]   io_m0_b_id,
    output logic [1:0]            io_m0_b_resp,
    input  logic                  io_m0_ar_valid,
    output logic                  io_m0_ar_ready,
    input  logic [XW-1:0]         io_m0_ar_bits,
    output logic                  io_m0_r_valid,
    input  logic                  io_m0_r_ready,
    output logic [ID_WIDTH-1:0]   io_m0_r_id,
    output logic [DATA_WIDTH-1:0] io_m0_r_data,
    output logic [1:0]            io_m0_r_resp,
    output logic                  io_m0_r_last,
    // master 1
    input  logic                  io_m1_aw_valid,
    output logic                  io_m1_aw_ready,
    input  logic [XW-1:0]         io_m1_aw_bits,
    input  logic                  io_m1_w_valid,
    output logic                  io_m1_w_ready,
    input  logic [DATA_WIDTH-1:0] io_m1_w_data,
    input  logic [SW-1:0]         io_m1_w_strb,
    input  logic                  io_m1_w_last,
    output logic                  io_m1_b_valid,
    input  logic                  io_m1_b_ready,
    output logic [ID_WIDTH-1:0]   io_m1_b_id,
    output logic [1:0]            io_m1_b_resp,
    input  logic                  io_m1_ar_valid,
    output logic                  io_m1_ar_ready,
    input  logic [XW-1:0]         io_m1_ar_bits,
    output logic                  io_m1_r_valid,
    input  logic                  io_m1_r_ready,
    output logic [ID_WIDTH-1:0]   io_m1_r_id,
    output logic [DATA_WIDTH-1:0] io_m1_r_data,
    output logic [1:0]            io_m1_r_resp,
    output logic                  io_m1_r_last,
    // DRAM slave
    output logic                  io_s_aw_valid,
    input  logic                  io_s_aw_ready,
    output logic [XW-1:0]         io_s_aw_bits,
    output logic                  io_s_w_valid,
    input  logic                  io_s_w_ready,
    output logic [DATA_WIDTH-1:0] io_s_w_data,
    output logic [SW-1:0]         io_s_w_strb,
    output logic                  io_s_w_last,
    input  logic                  io_s_b_valid,
    output logic                  io_s_b_ready,
    input  logic [ID_WIDTH-1:0]   io_s_b_id,
    input  logic [1:0]            io_s_b_resp,
    output logic                  io_s_ar_valid,
    input  logic                  io_s_ar_ready,
    output logic [XW-1:0]         io_s_ar_bits,
    input  logic                  io_s_r_valid,
    output logic                  io_s_r_ready,
    input  logic [ID_WIDTH-1:0]   io_s_r_id,
    input  logic [DATA_WIDTH-1:0] io_s_r_data,
    input  logic [1:0]            io_s_r_resp,
    input  logic                  io_s_r_last
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [1:0] wstate_q, wstate_d, rstate_q, rstate_d;
    logic       wgnt_q, wgnt_d, rgnt_q, rgnt_d;     // granted master (0/1)
    logic       wlast_q, wlast_d, rlast_q, rlast_d; // last completed winner

    // Sole requester wins; on a tie the master that did not win last time wins.
    function automatic logic pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) pick = ~last;
        else              pick = req1;
    endfunction

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wstate_q <= W_IDLE;
            wgnt_q   <= 1'b0;
            wlast_q  <= 1'b0;
            rstate_q <= R_IDLE;
            rgnt_q   <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wgnt_q   <= wgnt_d;
            wlast_q  <= wlast_d;
            rstate_q <= rstate_d;
            rgnt_q   <= rgnt_d;
            rlast_q  <= rlast_d;
        end
    end

    // Write path: next state and channel routing.
    always_comb begin
        wstate_d       = wstate_q;
        wgnt_d         = wgnt_q;
        wlast_d        = wlast_q;
        io_s_aw_valid  = 1'b0;
        io_s_aw_bits   = '0;
        io_m0_aw_ready = 1'b0;
        io_m1_aw_ready = 1'b0;
        io_s_w_valid   = 1'b0;
        io_s_w_data    = '0;
        io_s_w_strb    = '0;
        io_s_w_last    = 1'b0;
        io_m0_w_ready  = 1'b0;
        io_m1_w_ready  = 1'b0;
        io_m0_b_valid  = 1'b0;
        io_m0_b_id     = '0;
        io_m0_b_resp   = 2'b00;
        io_m1_b_valid  = 1'b0;
        io_m1_b_id     = '0;
        io_m1_b_resp   = 2'b00;
        io_s_b_ready   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (io_m0_aw_valid || io_m1_aw_valid) begin
                    wgnt_d   = pick(io_m0_aw_valid, io_m1_aw_valid, wlast_q);
                    wstate_d = W_ADDR;
                end
            end
            W_ADDR: begin
                io_s_aw_valid  = wgnt_q ? io_m1_aw_valid : io_m0_aw_valid;
                io_s_aw_bits   = wgnt_q ? io_m1_aw_bits  : io_m0_aw_bits;
                io_m0_aw_ready = !wgnt_q && io_s_aw_ready;
                io_m1_aw_ready =  wgnt_q && io_s_aw_ready;
                if ((wgnt_q ? io_m1_aw_valid : io_m0_aw_valid) && io_s_aw_ready)
                    wstate_d = W_DATA;
            end
            W_DATA: begin
                io_s_w_valid  = wgnt_q ? io_m1_w_valid : io_m0_w_valid;
                io_s_w_data   = wgnt_q ? io_m1_w_data  : io_m0_w_data;
                io_s_w_strb   = wgnt_q ? io_m1_w_strb  : io_m0_w_strb;
                io_s_w_last   = wgnt_q ? io_m1_w_last  : io_m0_w_last;
                io_m0_w_ready = !wgnt_q && io_s_w_ready;
                io_m1_w_ready =  wgnt_q && io_s_w_ready;
                if (io_s_w_valid && io_s_w_ready && io_s_w_last)
                    wstate_d = W_RESP;
            end
            W_RESP: begin
                io_m0_b_valid = !wgnt_q && io_s_b_valid;
                io_m1_b_valid =  wgnt_q && io_s_b_valid;
                if (wgnt_q) begin
                    io_m1_b_id   = io_s_b_id;
                    io_m1_b_resp = io_s_b_resp;
                end else begin
                    io_m0_b_id   = io_s_b_id;
                    io_m0_b_resp = io_s_b_resp;
                end
                io_s_b_ready = wgnt_q ? io_m1_b_ready : io_m0_b_ready;
                if (io_s_b_valid && io_s_b_ready) begin
                    wlast_d  = wgnt_q;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read path: next state and channel routing.
    always_comb begin
        rstate_d       = rstate_q;
        rgnt_d         = rgnt_q;
        rlast_d        = rlast_q;
        io_s_ar_valid  = 1'b0;
        io_s_ar_bits   = '0;
        io_m0_ar_ready = 1'b0;
        io_m1_ar_ready = 1'b0;
        io_m0_r_valid  = 1'b0;
        io_m0_r_id     = '0;
        io_m0_r_data   = '0;
        io_m0_r_resp   = 2'b00;
        io_m0_r_last   = 1'b0;
        io_m1_r_valid  = 1'b0;
        io_m1_r_id     = '0;
        io_m1_r_data   = '0;
        io_m1_r_resp   = 2'b00;
        io_m1_r_last   = 1'b0;
        io_s_r_ready   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (io_m0_ar_valid || io_m1_ar_valid) begin
                    rgnt_d   = pick(io_m0_ar_valid, io_m1_ar_valid, rlast_q);
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                io_s_ar_valid  = rgnt_q ? io_m1_ar_valid : io_m0_ar_valid;
                io_s_ar_bits   = rgnt_q ? io_m1_ar_bits  : io_m0_ar_bits;
                io_m0_ar_ready = !rgnt_q && io_s_ar_ready;
                io_m1_ar_ready =  rgnt_q && io_s_ar_ready;
                if ((rgnt_q ? io_m1_ar_valid : io_m0_ar_valid) && io_s_ar_ready)
                    rstate_d = R_DATA;
            end
            R_DATA: begin
                io_m0_r_valid = !rgnt_q && io_s_r_valid;
                io_m1_r_valid =  rgnt_q && io_s_r_valid;
                if (rgnt_q) begin
                    io_m1_r_id   = io_s_r_id;
                    io_m1_r_data = io_s_r_data;
                    io_m1_r_resp = io_s_r_resp;
                    io_m1_r_last = io_s_r_last;
                end else begin
                    io_m0_r_id   = io_s_r_id;
                    io_m0_r_data = io_s_r_data;
                    io_m0_r_resp = io_s_r_resp;
                    io_m0_r_last = io_s_r_last;
                end
                io_s_r_ready = rgnt_q ? io_m1_r_ready : io_m0_r_ready;
                if (io_s_r_valid && io_s_r_ready && io_s_r_last) begin
                    rlast_d  = rgnt_q;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

endmodule
